// File: rtl/mfp_sword_7seg_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : mfp_sword_7seg_serializer
//  Purpose  : Turns the GPIO 7-segment registers (8 hex digits plus a digit
//             enable mask) into a 64-bit active-low segment frame. The frame
//             is shifted into the SWORD board's 74HC595 chain with digit 7
//             first and MSB first, and a latch pulse follows. A new frame is
//             sent only when the inputs differ from the last frame sent. One
//             frame is always sent after reset.
//  Ports    : HCLK      - system clock
//             HRESET    - synchronous active-high reset
//             IO_7SEG   - hex digits, digit i = IO_7SEG[4i+3:4i]
//             IO_7SEGE  - digit enable, bit i = 0 blanks digit i
//             IO_7SEGDP - decimal-point enable (only with MFP_SEG_DP_EN)
//             SEG_SCLK  - 74HC595 shift clock
//             SEG_SDO   - serial data, stable around the SCLK rising edge
//             SEG_LATCH - storage-register latch pulse, active high
//             SEG_OEn   - display output enable, active low
//             SEG_BUSY  - high during LOAD/SHIFT/LATCH
//  Options  : MFP_SEG_DP_EN - adds IO_7SEGDP and drives the per-digit DP bit
//  Revision : 1.0 - initial release
// ============================================================================
module mfp_sword_7seg_serializer #(
    parameter int CLK_DIV = 2
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] IO_7SEG,
    input  logic [7:0]  IO_7SEGE,
`ifdef MFP_SEG_DP_EN
    input  logic [7:0]  IO_7SEGDP,
`endif
    output logic        SEG_SCLK,
    output logic        SEG_SDO,
    output logic        SEG_LATCH,
    output logic        SEG_OEn,
    output logic        SEG_BUSY
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLK_DIV - 1);

`ifdef MFP_SEG_DP_EN
    localparam int SNAP_W = 48;
    wire [7:0]        w_dp  = IO_7SEGDP;
    wire [SNAP_W-1:0] w_cur = {IO_7SEGDP, IO_7SEGE, IO_7SEG};
`else
    localparam int SNAP_W = 40;
    wire [7:0]        w_dp  = 8'h00;
    wire [SNAP_W-1:0] w_cur = {IO_7SEGE, IO_7SEG};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_LATCH = 2'd3
    } state_t;

    state_t            r_state;
    logic [SNAP_W-1:0] r_snap;
    logic              r_pending;
    logic [63:0]       r_shreg;
    logic [5:0]        r_bit;
    logic [DIV_W-1:0]  r_div;
    logic [63:0]       w_frame;

    // Active-low segments {G,F,E,D,C,B,A}; the DP bit is added separately.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Digit i occupies frame byte i, so digit 7 sits in bits 63:56 and goes out first.
    always_comb begin
        w_frame = '1;
        for (int i = 0; i < 8; i++) begin
            if (IO_7SEGE[i]) begin
                w_frame[8*i +: 8] = {~w_dp[i], hex_to_seg(IO_7SEG[4*i +: 4])};
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= S_IDLE;
            r_snap    <= '0;
            r_pending <= 1'b1;
            r_shreg   <= '0;
            r_bit     <= '0;
            r_div     <= '0;
            SEG_SCLK  <= 1'b0;
            SEG_SDO   <= 1'b0;
            SEG_LATCH <= 1'b0;
            SEG_OEn   <= 1'b1;
            SEG_BUSY  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending || (w_cur != r_snap)) begin
                        r_state  <= S_LOAD;
                        SEG_BUSY <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // Inputs are frozen here; later changes wait for the next IDLE compare.
                    r_snap    <= w_cur;
                    r_pending <= 1'b0;
                    r_shreg   <= w_frame;
                    SEG_SDO   <= w_frame[63];
                    SEG_SCLK  <= 1'b0;
                    r_bit     <= '0;
                    r_div     <= '0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_div != c_div_last) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!SEG_SCLK) begin
                            SEG_SCLK <= 1'b1;
                        end else if (r_bit == 6'd63) begin
                            SEG_SCLK  <= 1'b0;
                            SEG_LATCH <= 1'b1;
                            r_state   <= S_LATCH;
                        end else begin
                            // Entering the low phase of the next bit: the only point SDO moves.
                            SEG_SCLK <= 1'b0;
                            SEG_SDO  <= r_shreg[62];
                            r_shreg  <= {r_shreg[62:0], 1'b0};
                            r_bit    <= r_bit + 1'b1;
                        end
                    end
                end
                default: begin // S_LATCH
                    if (r_div != c_div_last) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div     <= '0;
                        SEG_LATCH <= 1'b0;
                        SEG_OEn   <= 1'b0;
                        SEG_BUSY  <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
